iic_bus_monitor: RTL and testbench
==================================

// Module: iic_bus_monitor
// PURPOSE
//   Decodes I2C bus activity from the filtered SCL/SDA lines. Its inputs come from the glitch filters.
//   - Detects START, repeated START and STOP conditions.
//   - Shifts in 8-bit bytes MSB-first and samples the 9th (ACK) bit.
//   - Reports each completed byte with a one-cycle valid pulse and an address/data tag.
//   - Feeds the slave/transaction FSM downstream.
// PARAMETERS
//   CLK_FREQ    `GCLK_FREQ  system clock frequency in Hz
//   TIMEOUT_US  25000       SCL-low timeout in us; used only with IIC_MON_TIMEOUT_EN
// PORTS
//   CLK            in   1  system clock
//   RSTn           in   1  asynchronous, active-low reset
//   SCL_In         in   1  filtered SCL, already registered in the CLK domain
//   SDA_In         in   1  filtered SDA, already registered in the CLK domain
//   Byte_Out       out  8  last completed byte; held until the next byte completes
//   Byte_Valid     out  1  one-cycle pulse; Byte_Out, Byte_Is_Addr and Ack_Out are valid this cycle
//   Byte_Is_Addr   out  1  1 = byte is the first after a START/repeated START (address + R/W)
//   Ack_Out        out  1  SDA sampled on the 9th SCL rise (0 = ACK, 1 = NACK)
//   Start_Pulse    out  1  one-cycle pulse on START or repeated START
//   Stop_Pulse     out  1  one-cycle pulse on STOP
//   Bus_Busy       out  1  high from START until STOP or timeout
//   Timeout_Pulse  out  1  one-cycle pulse on SCL-low timeout; constant 0 without the macro
// BEHAVIOUR
//   Reset values:
//     - scl_q = sda_q = 1
//     - Byte_Out = 0, Ack_Out = 1
//     - Byte_Valid, Byte_Is_Addr, Start_Pulse, Stop_Pulse, Bus_Busy, Timeout_Pulse = 0
//     - state = IDLE, bit_cnt = 0
//   Edge detection: scl_q/sda_q hold the previous samples.
//     - scl_rise = SCL_In & ~scl_q
//     - START    = scl_q & SCL_In & sda_q & ~SDA_In
//     - STOP     = scl_q & SCL_In & ~sda_q & SDA_In
//     - If SCL and SDA change in the same cycle, no condition is flagged; the SCL edge alone is acted on.
//   FSM: IDLE, DATA, ACK.
//     - IDLE: scl_rise is ignored. START -> DATA, Bus_Busy = 1, first = 1, bit_cnt = 0.
//     - DATA: on scl_rise, shreg = {shreg[6:0], SDA_In} and bit_cnt++. When bit_cnt reaches 8 -> ACK.
//     - ACK: on scl_rise:
//         * Byte_Out = shreg, Ack_Out = SDA_In, Byte_Is_Addr = first, Byte_Valid pulses.
//         * Then first = 0, bit_cnt = 0, next state DATA.
//     - START in any state (repeated START):
//         * Start_Pulse, the partial byte is discarded with no Byte_Valid.
//         * bit_cnt = 0, first = 1, next state DATA.
//     - STOP in any non-IDLE state: Stop_Pulse, discard the partial byte, Bus_Busy = 0 -> IDLE.
//     - STOP in IDLE: Stop_Pulse only.
//   Latency: every output pulse is registered and appears 1 CLK after the sample that triggers it.
//   Byte_Is_Addr and Ack_Out hold their values until the next Byte_Valid.
//   Asserting RSTn low mid-byte returns everything to its reset values; no pulse is produced.
// CONFIGURATION
//   IIC_MON_TIMEOUT_EN defined:
//     - A counter of width GetValLen(TO_CYC) counts while Bus_Busy & ~SCL_In.
//     - TO_CYC = CLK_FREQ / 1_000_000 * TIMEOUT_US.
//     - The counter clears on any SCL high, and while the bus is idle.
//     - On reaching TO_CYC: Timeout_Pulse, Bus_Busy = 0, state -> IDLE, partial byte discarded.
//     - If START/STOP and the timeout occur in the same cycle, START/STOP wins.
//   IIC_MON_TIMEOUT_EN undefined: no counter is built, Timeout_Pulse is tied to 0.
// STRUCTURE
//   Shared package/include: IIC_ST_IDLE/DATA/ACK state encodings, the GetValLen width function,
//   and the `GCLK_FREQ define.
//   Sub-module iic_cond_detect:
//     - Holds the scl_q/sda_q registers.
//     - Outputs scl_rise, start_det and stop_det.
//     - Is reusable by the master FSM.
// TESTING
//   1. Reset, then START, byte 0xA0, ACK = 0, STOP
//      -> Start_Pulse x1; Byte_Valid x1 with Byte_Out = 0xA0, Byte_Is_Addr = 1, Ack_Out = 0;
//         Stop_Pulse x1; Bus_Busy 1 -> 0.
//   2. START, 0x50 + ACK, 0x3C + NACK, STOP
//      -> two Byte_Valid: (0x50, addr = 1, ack = 0) then (0x3C, addr = 0, ack = 1).
//   3. START, 4 bits of 0xF_, repeated START, 0x51 + ACK
//      -> no Byte_Valid for the partial byte; Start_Pulse x2; then Byte_Valid 0x51 with addr = 1.
//   4. SCL and SDA toggled in the same cycle while SCL is high
//      -> no Start_Pulse or Stop_Pulse; Bus_Busy unchanged.
//   5. RSTn pulsed low after bit 5
//      -> all outputs at reset values; the next START/byte decodes normally with addr = 1.
//   6. With the macro, CLK_FREQ = 1_000_000 and TIMEOUT_US = 100: START, then SCL held low 100 cycles
//      -> Timeout_Pulse at cycle 100 and Bus_Busy = 0.
//      Without the macro, Timeout_Pulse stays 0.

Source files
------------

// File: rtl/iic_bus_monitor_pkg.sv
// Shared definitions for the I2C bus monitor: state encodings, width helper and system clock default.
`ifndef GCLK_FREQ
`define GCLK_FREQ 50_000_000
`endif

package iic_bus_monitor_pkg;

   typedef enum logic [1:0] {
      IIC_ST_IDLE = 2'd0,
      IIC_ST_DATA = 2'd1,
      IIC_ST_ACK  = 2'd2
   } iic_state_t;

   // Number of bits needed to hold val (minimum 1).
   function automatic int GetValLen(input longint unsigned val);
      int len;
      len = 1;
      for (int i = 1; i < 64; i++) begin
         if ((val >> i) != 0) len = i + 1;
      end
      return len;
   endfunction

endpackage

// File: rtl/iic_bus_monitor_cond_detect.sv
// START/STOP/SCL-rise detector on the filtered, already-registered SCL/SDA lines.
// Shared with the master FSM; holds the previous-sample registers.
module iic_cond_detect
   import iic_bus_monitor_pkg::*;
(
   input  logic CLK,
   input  logic RSTn,
   input  logic SCL_In,
   input  logic SDA_In,
   output logic scl_rise,
   output logic start_det,
   output logic stop_det
);

   logic scl_q;
   logic sda_q;

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         scl_q <= 1'b1;
         sda_q <= 1'b1;
      end else begin
         scl_q <= SCL_In;
         sda_q <= SDA_In;
      end
   end

   // Conditions need SCL stable high, so a simultaneous SCL/SDA change never flags one.
   assign scl_rise  = SCL_In & ~scl_q;
   assign start_det = scl_q & SCL_In & sda_q & ~SDA_In;
   assign stop_det  = scl_q & SCL_In & ~sda_q & SDA_In;

endmodule

// File: rtl/iic_bus_monitor.sv
// I2C bus monitor: decodes START/STOP and bytes with their ACK bit from filtered SCL/SDA.
// Optional SCL-low timeout is built only when IIC_MON_TIMEOUT_EN is defined.
//
// state        | meaning
// IIC_ST_IDLE  | bus free, waiting for START
// IIC_ST_DATA  | shifting in the 8 data bits
// IIC_ST_ACK   | waiting for the 9th SCL rise to sample ACK
`ifndef GCLK_FREQ
`define GCLK_FREQ 50_000_000
`endif

module iic_bus_monitor
   import iic_bus_monitor_pkg::*;
#(
   parameter int unsigned CLK_FREQ   = `GCLK_FREQ,
   parameter int unsigned TIMEOUT_US = 25000
) (
   input  logic       CLK,
   input  logic       RSTn,
   input  logic       SCL_In,
   input  logic       SDA_In,
   output logic [7:0] Byte_Out,
   output logic       Byte_Valid,
   output logic       Byte_Is_Addr,
   output logic       Ack_Out,
   output logic       Start_Pulse,
   output logic       Stop_Pulse,
   output logic       Bus_Busy,
   output logic       Timeout_Pulse
);

   if (CLK_FREQ < 1_000_000 || TIMEOUT_US == 0) begin : g_cfg_check
      $error("iic_bus_monitor: CLK_FREQ must be >= 1 MHz and TIMEOUT_US nonzero");
   end

   iic_state_t state_q;
   iic_state_t state_d;
   logic [3:0] bit_cnt;
   logic [7:0] shreg;
   logic       first;
   logic       scl_rise;
   logic       start_det;
   logic       stop_det;
   logic       to_hit;
   logic       abort;
   logic       do_shift;
   logic       do_byte;

   iic_cond_detect u_cond (
      .CLK       (CLK),
      .RSTn      (RSTn),
      .SCL_In    (SCL_In),
      .SDA_In    (SDA_In),
      .scl_rise  (scl_rise),
      .start_det (start_det),
      .stop_det  (stop_det)
   );

`ifdef IIC_MON_TIMEOUT_EN
   localparam int unsigned TO_CYC = CLK_FREQ / 1_000_000 * TIMEOUT_US;
   localparam int          TO_W   = GetValLen(TO_CYC);

   logic [TO_W-1:0] to_cnt;

   // Down-counter reloads whenever SCL is high or the bus is idle; hits on the TO_CYC-th low sample.
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         to_cnt <= TO_W'(TO_CYC - 1);
      end else if (!Bus_Busy || SCL_In) begin
         to_cnt <= TO_W'(TO_CYC - 1);
      end else if (to_cnt != '0) begin
         to_cnt <= to_cnt - 1'b1;
      end
   end

   assign to_hit = Bus_Busy & ~SCL_In & (to_cnt == '0);
`else
   assign to_hit = 1'b0;
`endif

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) state_q <= IIC_ST_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (start_det) begin
         state_d = IIC_ST_DATA;
      end else if (stop_det || to_hit) begin
         state_d = IIC_ST_IDLE;
      end else begin
         case (state_q)
            IIC_ST_DATA: if (scl_rise && bit_cnt == 4'd7) state_d = IIC_ST_ACK;
            IIC_ST_ACK:  if (scl_rise) state_d = IIC_ST_DATA;
            default:     state_d = state_q;
         endcase
      end
   end

   always_comb begin
      abort    = start_det | stop_det | to_hit;
      do_shift = (state_q == IIC_ST_DATA) & scl_rise & ~abort;
      do_byte  = (state_q == IIC_ST_ACK) & scl_rise & ~abort;
   end

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         bit_cnt       <= 4'd0;
         shreg         <= 8'h00;
         first         <= 1'b0;
         Byte_Out      <= 8'h00;
         Byte_Valid    <= 1'b0;
         Byte_Is_Addr  <= 1'b0;
         Ack_Out       <= 1'b1;
         Start_Pulse   <= 1'b0;
         Stop_Pulse    <= 1'b0;
         Bus_Busy      <= 1'b0;
         Timeout_Pulse <= 1'b0;
      end else begin
         Byte_Valid    <= 1'b0;
         Start_Pulse   <= start_det;
         Stop_Pulse    <= stop_det;
         Timeout_Pulse <= to_hit & ~start_det & ~stop_det;
         if (start_det) begin
            bit_cnt  <= 4'd0;
            first    <= 1'b1;
            Bus_Busy <= 1'b1;
         end else if (stop_det || to_hit) begin
            bit_cnt  <= 4'd0;
            Bus_Busy <= 1'b0;
         end else if (do_shift) begin
            shreg   <= {shreg[6:0], SDA_In};
            bit_cnt <= bit_cnt + 4'd1;
         end else if (do_byte) begin
            Byte_Out     <= shreg;
            Ack_Out      <= SDA_In;
            Byte_Is_Addr <= first;
            Byte_Valid   <= 1'b1;
            first        <= 1'b0;
            bit_cnt      <= 4'd0;
         end
      end
   end

endmodule

// File: tb/tb_iic_bus_monitor.sv
// Bench for iic_bus_monitor: directed bus scenarios plus random transactions against a byte-level model.
module tb_iic_bus_monitor;

   logic       CLK = 1'b0;
   logic       RSTn = 1'b0;
   logic       SCL_In = 1'b1;
   logic       SDA_In = 1'b1;
   logic [7:0] Byte_Out;
   logic       Byte_Valid;
   logic       Byte_Is_Addr;
   logic       Ack_Out;
   logic       Start_Pulse;
   logic       Stop_Pulse;
   logic       Bus_Busy;
   logic       Timeout_Pulse;

   int checks = 0;
   int failures = 0;

   // Observed activity, recorded by the monitor process only.
   int         n_start = 0;
   int         n_stop = 0;
   int         n_to = 0;
   logic [9:0] evq[$];
   int         ev_rd = 0;

   // Model: every completed byte after a START, the first one flagged as address.
   logic [9:0] exp_q[$];
   int         exp_rd = 0;
   bit         exp_first = 1'b0;

   always #5 CLK = ~CLK;

   iic_bus_monitor #(.CLK_FREQ(1_000_000), .TIMEOUT_US(100)) dut (
      .CLK           (CLK),
      .RSTn          (RSTn),
      .SCL_In        (SCL_In),
      .SDA_In        (SDA_In),
      .Byte_Out      (Byte_Out),
      .Byte_Valid    (Byte_Valid),
      .Byte_Is_Addr  (Byte_Is_Addr),
      .Ack_Out       (Ack_Out),
      .Start_Pulse   (Start_Pulse),
      .Stop_Pulse    (Stop_Pulse),
      .Bus_Busy      (Bus_Busy),
      .Timeout_Pulse (Timeout_Pulse)
   );

   always @(negedge CLK) begin
      if (RSTn) begin
         if (Byte_Valid)    evq.push_back({Byte_Is_Addr, Ack_Out, Byte_Out});
         if (Start_Pulse)   n_start++;
         if (Stop_Pulse)    n_stop++;
         if (Timeout_Pulse) n_to++;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_lines(input logic scl, input logic sda, input int n);
      @(negedge CLK);
      SCL_In = scl;
      SDA_In = sda;
      repeat (n - 1) @(negedge CLK);
   endtask

   task automatic settle();
      repeat (3) @(negedge CLK);
      #1;
   endtask

   task automatic start_cond();
      set_lines(1, 1, 2);
      set_lines(1, 0, 2);
      set_lines(0, 0, 2);
      exp_first = 1'b1;
   endtask

   task automatic rstart_cond();
      set_lines(0, 1, 2);
      set_lines(1, 1, 2);
      set_lines(1, 0, 2);
      set_lines(0, 0, 2);
      exp_first = 1'b1;
   endtask

   task automatic stop_cond();
      set_lines(0, 0, 2);
      set_lines(1, 0, 2);
      set_lines(1, 1, 2);
   endtask

   task automatic send_bit(input logic b);
      set_lines(0, b, 2);
      set_lines(1, b, 2);
      set_lines(0, b, 2);
   endtask

   task automatic send_bits(input logic [7:0] v, input int n);
      for (int i = 0; i < n; i++) send_bit(v[7 - i]);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic ack);
      send_bits(b, 8);
      send_bit(ack);
      exp_q.push_back({exp_first, ack, b});
      exp_first = 1'b0;
   endtask

   task automatic check_events(input string tag);
      int got;
      int want;
      logic [9:0] e;
      logic [9:0] x;
      got  = evq.size() - ev_rd;
      want = exp_q.size() - exp_rd;
      chk({tag, "_count"}, got, want);
      for (int i = 0; i < want && i < got; i++) begin
         e = evq[ev_rd + i];
         x = exp_q[exp_rd + i];
         chk({tag, "_byte"}, e[7:0], x[7:0]);
         chk({tag, "_addr"}, e[9], x[9]);
         chk({tag, "_ack"}, e[8], x[8]);
      end
      ev_rd  = evq.size();
      exp_rd = exp_q.size();
   endtask

   initial begin
      int s_start;
      int s_stop;
      int s_to;
      int to_at;
      logic [7:0] rb;
      logic       ra;
      logic [7:0] last_b;

      repeat (3) @(negedge CLK);
      RSTn = 1'b1;
      settle();
      chk("rst_byte_out", Byte_Out, 8'h00);
      chk("rst_ack_out", Ack_Out, 1'b1);
      chk("rst_valid", Byte_Valid, 1'b0);
      chk("rst_is_addr", Byte_Is_Addr, 1'b0);
      chk("rst_start", Start_Pulse, 1'b0);
      chk("rst_stop", Stop_Pulse, 1'b0);
      chk("rst_busy", Bus_Busy, 1'b0);
      chk("rst_timeout", Timeout_Pulse, 1'b0);

      // 1: single address byte
      s_start = n_start; s_stop = n_stop;
      start_cond();
      chk("t1_busy_on", Bus_Busy, 1'b1);
      chk("t1_start_cnt", n_start - s_start, 1);
      send_byte(8'hA0, 1'b0);
      stop_cond();
      settle();
      chk("t1_stop_cnt", n_stop - s_stop, 1);
      chk("t1_busy_off", Bus_Busy, 1'b0);
      check_events("t1");
      chk("t1_hold", Byte_Out, 8'hA0);

      // 2: address + data with NACK
      start_cond();
      send_byte(8'h50, 1'b0);
      send_byte(8'h3C, 1'b1);
      stop_cond();
      settle();
      check_events("t2");
      chk("t2_ack_hold", Ack_Out, 1'b1);
      chk("t2_addr_hold", Byte_Is_Addr, 1'b0);

      // 3: partial byte discarded by repeated START
      s_start = n_start;
      start_cond();
      send_bits(8'hF0, 4);
      rstart_cond();
      send_byte(8'h51, 1'b0);
      stop_cond();
      settle();
      chk("t3_start_cnt", n_start - s_start, 2);
      check_events("t3");

      // 4: simultaneous SCL/SDA changes flag nothing, idle and busy
      s_start = n_start; s_stop = n_stop;
      set_lines(0, 0, 2);
      set_lines(1, 1, 2);
      settle();
      chk("t4_idle_start", n_start - s_start, 0);
      chk("t4_idle_stop", n_stop - s_stop, 0);
      chk("t4_idle_busy", Bus_Busy, 1'b0);
      start_cond();
      set_lines(1, 1, 2);
      set_lines(0, 0, 2);
      chk("t4_busy_held", Bus_Busy, 1'b1);
      chk("t4_stop_none", n_stop - s_stop, 0);
      send_bits(8'h86, 7);
      send_bit(1'b0);
      exp_q.push_back({exp_first, 1'b0, 8'hC3});
      exp_first = 1'b0;
      stop_cond();
      settle();
      chk("t4_start_cnt", n_start - s_start, 1);
      chk("t4_stop_cnt", n_stop - s_stop, 1);
      check_events("t4");

      // 5: reset mid-byte
      start_cond();
      send_bits(8'hB5, 5);
      s_start = n_start; s_stop = n_stop;
      @(negedge CLK);
      RSTn = 1'b0;
      SCL_In = 1'b1;
      SDA_In = 1'b1;
      repeat (2) @(negedge CLK);
      #1;
      chk("t5_byte_out", Byte_Out, 8'h00);
      chk("t5_ack_out", Ack_Out, 1'b1);
      chk("t5_is_addr", Byte_Is_Addr, 1'b0);
      chk("t5_busy", Bus_Busy, 1'b0);
      @(negedge CLK);
      RSTn = 1'b1;
      settle();
      chk("t5_no_start", n_start - s_start, 0);
      chk("t5_no_stop", n_stop - s_stop, 0);
      check_events("t5_rst");
      rb = 8'($urandom);
      start_cond();
      send_byte(rb, 1'b0);
      stop_cond();
      settle();
      check_events("t5_after");

      // 6: SCL held low after START
      s_to = n_to;
      to_at = 0;
      set_lines(1, 1, 2);
      set_lines(1, 0, 2);
      set_lines(0, 0, 1);
      for (int c = 1; c <= 200; c++) begin
         @(negedge CLK);
         if (Timeout_Pulse && to_at == 0) to_at = c;
      end
      #1;
`ifdef IIC_MON_TIMEOUT_EN
      chk("t6_to_cycle", to_at, 100);
      chk("t6_to_cnt", n_to - s_to, 1);
      chk("t6_busy", Bus_Busy, 1'b0);
`else
      chk("t6_to_cycle", to_at, 0);
      chk("t6_to_cnt", n_to - s_to, 0);
      chk("t6_busy", Bus_Busy, 1'b1);
`endif
      stop_cond();
      settle();
      chk("t6_busy_end", Bus_Busy, 1'b0);
      check_events("t6");

      // Random transactions, optionally with a repeated START
      last_b = 8'h00;
      for (int t = 0; t < 8; t++) begin
         start_cond();
         for (int k = 0; k < int'($urandom_range(1, 4)); k++) begin
            rb = 8'($urandom);
            ra = 1'($urandom);
            send_byte(rb, ra);
            last_b = rb;
         end
         if ($urandom_range(0, 1) == 1) begin
            send_bits(8'($urandom), int'($urandom_range(1, 7)));
            rstart_cond();
            rb = 8'($urandom);
            send_byte(rb, 1'b1);
            last_b = rb;
         end
         stop_cond();
         settle();
         check_events($sformatf("rnd%0d", t));
         chk($sformatf("rnd%0d_hold", t), Byte_Out, last_b);
         chk($sformatf("rnd%0d_busy", t), Bus_Busy, 1'b0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
